// File: rtl/pack_vldrdy_pkg.sv
// Shared types and default sizes for the width-doubling stream packer.
package pack_vldrdy_pkg;
  typedef enum logic {ST_EMPTY = 1'b0, ST_HALF = 1'b1} pack_state_t;
  localparam int DWIDTH_DEF = 8;
  localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/vldrdy_out_reg.sv
// Valid/ready output register stage: load, drain, or hold one word.
module vldrdy_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] data,
  output logic         out_val,
  output logic         out_acc
);
  // en gates visibility only; the held word survives a disable.
  assign out_val = vld && en;
  assign out_acc = out_val && rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
    end else if (out_acc) begin
      vld  <= 1'b0;
    end
  end
endmodule

// File: rtl/pack_vldrdy.sv
// Pairs consecutive DWIDTH-bit input words into one 2*DWIDTH-bit output word.
module pack_vldrdy
  import pack_vldrdy_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic                cfg_flush,
  input  logic                src_val,
  output logic                src_rdy,
  input  logic [DWIDTH-1:0]   src_data,
  output logic                dst_val,
  input  logic                dst_rdy,
  output logic [2*DWIDTH-1:0] dst_data,
  output logic [CNT_W-1:0]    word_cnt,
  output logic                half_pend
);
  pack_state_t       state, state_nxt;
  logic [DWIDTH-1:0] hold_reg, hold_nxt;
  logic              out_vld, out_acc, load, in_acc;

  // Completing a pair needs room in the output register, which may free up this cycle.
  assign src_rdy   = cfg_en && !rst && (state == ST_EMPTY || !out_vld || dst_rdy);
  assign in_acc    = src_val && src_rdy;
  assign half_pend = (state == ST_HALF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      hold_reg <= '0;
    end else begin
      state    <= state_nxt;
      hold_reg <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_reg;
    load      = 1'b0;
    if (cfg_flush) begin
      // Flush drops the held half; a word taken now starts a fresh pair.
      state_nxt = in_acc ? ST_HALF : ST_EMPTY;
      if (in_acc) hold_nxt = src_data;
    end else if (in_acc) begin
      if (state == ST_EMPTY) begin
        hold_nxt  = src_data;
        state_nxt = ST_HALF;
      end else begin
        load      = 1'b1;
        state_nxt = ST_EMPTY;
      end
    end
  end

  vldrdy_out_reg #(.W(2*DWIDTH)) u_out (
    .clk       (clk),
    .rst       (rst),
    .en        (cfg_en),
    .load      (load),
    .load_data ({hold_reg, src_data}),
    .rdy       (dst_rdy),
    .vld       (out_vld),
    .data      (dst_data),
    .out_val   (dst_val),
    .out_acc   (out_acc)
  );

  always_ff @(posedge clk) begin
    if (rst)          word_cnt <= '0;
    else if (out_acc) word_cnt <= word_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pack_vldrdy.sv
// Directed bench for pack_vldrdy; a second CNT_W=4 instance exercises counter wrap.
module tb_pack_vldrdy;
  logic        clk = 1'b0;
  logic        rst, cfg_en, cfg_flush, src_val, dst_rdy;
  logic [7:0]  src_data;
  logic        src_rdy, dst_val, half_pend;
  logic [15:0] dst_data, word_cnt;
  logic        s_src_rdy, s_dst_val, s_half_pend;
  logic [15:0] s_dst_data;
  logic [3:0]  s_word_cnt;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pack_vldrdy #(.DWIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_flush(cfg_flush),
    .src_val(src_val), .src_rdy(src_rdy), .src_data(src_data),
    .dst_val(dst_val), .dst_rdy(dst_rdy), .dst_data(dst_data),
    .word_cnt(word_cnt), .half_pend(half_pend)
  );

  pack_vldrdy #(.DWIDTH(8), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_flush(cfg_flush),
    .src_val(src_val), .src_rdy(s_src_rdy), .src_data(src_data),
    .dst_val(s_dst_val), .dst_rdy(dst_rdy), .dst_data(s_dst_data),
    .word_cnt(s_word_cnt), .half_pend(s_half_pend)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    src_val = v; src_data = d; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    tests++; if (src_rdy !== 1'b0)    begin fails++; $display("FAIL reset_src_rdy got %b exp 0", src_rdy); end
    tests++; if (dst_val !== 1'b0)    begin fails++; $display("FAIL reset_dst_val got %b exp 0", dst_val); end
    tests++; if (dst_data !== 16'h0)  begin fails++; $display("FAIL reset_dst_data got %h exp 0000", dst_data); end
    tests++; if (word_cnt !== 16'h0)  begin fails++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
    tests++; if (half_pend !== 1'b0)  begin fails++; $display("FAIL reset_half_pend got %b exp 0", half_pend); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0]  w[4];
    logic [15:0] exp_o[2];
    int n = 0;
    bit rdy_ok = 1'b1;
    w = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_o = '{16'h1234, 16'h5678};
    dst_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, w[i]); else drive(1'b0, 8'h00);
      if (i < 4 && src_rdy !== 1'b1) rdy_ok = 1'b0;
      if (dst_val && dst_rdy) begin
        tests++;
        if (n > 1 || dst_data !== exp_o[n]) begin
          fails++; $display("FAIL stream_data[%0d] got %h exp %h", n, dst_data, (n < 2) ? exp_o[n] : 16'hxxxx);
        end
        n++;
      end
      step();
    end
    tests++; if (n != 2)            begin fails++; $display("FAIL stream_count got %0d exp 2", n); end
    tests++; if (!rdy_ok)           begin fails++; $display("FAIL stream_src_rdy got bubble exp none"); end
    tests++; if (word_cnt !== 16'd2) begin fails++; $display("FAIL stream_word_cnt got %0d exp 2", word_cnt); end
  endtask

  task automatic test_backpressure();
    dst_rdy = 1'b0;
    drive(1'b1, 8'hAB); step();
    drive(1'b1, 8'hCD); step();
    src_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (dst_val !== 1'b1 || dst_data !== 16'hABCD) begin
        fails++; $display("FAIL bp_hold[%0d] got val %b data %h exp 1 abcd", i, dst_val, dst_data);
      end
      step();
    end
    drive(1'b1, 8'h01);
    tests++; if (src_rdy !== 1'b1) begin fails++; $display("FAIL bp_first_rdy got %b exp 1", src_rdy); end
    step();
    drive(1'b1, 8'h02);
    for (int i = 0; i < 2; i++) begin
      tests++; if (src_rdy !== 1'b0) begin fails++; $display("FAIL bp_partner_refused got %b exp 0", src_rdy); end
      step();
    end
    tests++; if (dst_data !== 16'hABCD) begin fails++; $display("FAIL bp_still_held got %h exp abcd", dst_data); end
    dst_rdy = 1'b1; #1;
    tests++; if (src_rdy !== 1'b1) begin fails++; $display("FAIL bp_partner_rdy got %b exp 1", src_rdy); end
    step();
    src_val = 1'b0; #1;
    tests++;
    if (dst_val !== 1'b1 || dst_data !== 16'h0102 || word_cnt !== 16'd3) begin
      fails++; $display("FAIL bp_next got val %b data %h cnt %0d exp 1 0102 3", dst_val, dst_data, word_cnt);
    end
    step();
    tests++; if (word_cnt !== 16'd4 || dst_val !== 1'b0) begin fails++; $display("FAIL bp_drain got cnt %0d val %b exp 4 0", word_cnt, dst_val); end
  endtask

  task automatic test_flush();
    dst_rdy = 1'b1;
    drive(1'b1, 8'h11); step();
    tests++; if (half_pend !== 1'b1) begin fails++; $display("FAIL flush_pre_half got %b exp 1", half_pend); end
    src_val = 1'b0; cfg_flush = 1'b1; step(); cfg_flush = 1'b0;
    tests++; if (half_pend !== 1'b0) begin fails++; $display("FAIL flush_half got %b exp 0", half_pend); end
    drive(1'b1, 8'h22); step();
    drive(1'b1, 8'h33); step();
    src_val = 1'b0; #1;
    tests++;
    if (dst_val !== 1'b1 || dst_data !== 16'h2233 || half_pend !== 1'b0) begin
      fails++; $display("FAIL flush_out got val %b data %h half %b exp 1 2233 0", dst_val, dst_data, half_pend);
    end
    step();
    drive(1'b1, 8'h44); step();
    cfg_flush = 1'b1; drive(1'b1, 8'h55); step(); cfg_flush = 1'b0;
    tests++; if (half_pend !== 1'b1) begin fails++; $display("FAIL flush_accept_half got %b exp 1", half_pend); end
    drive(1'b1, 8'h66); step();
    src_val = 1'b0; #1;
    tests++; if (dst_data !== 16'h5566) begin fails++; $display("FAIL flush_accept_out got %h exp 5566", dst_data); end
    step();
    tests++; if (word_cnt !== 16'd6) begin fails++; $display("FAIL flush_word_cnt got %0d exp 6", word_cnt); end
  endtask

  task automatic test_enable();
    dst_rdy = 1'b0;
    drive(1'b1, 8'h77); step();
    drive(1'b1, 8'h88); step();
    drive(1'b1, 8'h99); step();
    cfg_en = 1'b0; dst_rdy = 1'b1; drive(1'b1, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (src_rdy !== 1'b0 || dst_val !== 1'b0 || half_pend !== 1'b1) begin
        fails++; $display("FAIL en_off[%0d] got rdy %b val %b half %b exp 0 0 1", i, src_rdy, dst_val, half_pend);
      end
      step();
    end
    tests++; if (word_cnt !== 16'd6) begin fails++; $display("FAIL en_off_cnt got %0d exp 6", word_cnt); end
    cfg_en = 1'b1; dst_rdy = 1'b0; #1;
    tests++;
    if (dst_val !== 1'b1 || dst_data !== 16'h7788 || src_rdy !== 1'b0) begin
      fails++; $display("FAIL en_resume got val %b data %h rdy %b exp 1 7788 0", dst_val, dst_data, src_rdy);
    end
    dst_rdy = 1'b1; #1; step();
    src_val = 1'b0; #1;
    tests++; if (dst_data !== 16'h99AA || word_cnt !== 16'd7) begin fails++; $display("FAIL en_pair got %h cnt %0d exp 99aa 7", dst_data, word_cnt); end
    step();
    tests++; if (word_cnt !== 16'd8) begin fails++; $display("FAIL en_word_cnt got %0d exp 8", word_cnt); end
  endtask

  task automatic test_rst_mid();
    dst_rdy = 1'b0;
    drive(1'b1, 8'h01); step();
    drive(1'b1, 8'h02); step();
    drive(1'b1, 8'h03); step();
    src_val = 1'b0; rst = 1'b1; step();
    tests++;
    if (src_rdy !== 1'b0 || dst_val !== 1'b0 || dst_data !== 16'h0 || word_cnt !== 16'h0 || half_pend !== 1'b0) begin
      fails++; $display("FAIL rst_mid got rdy %b val %b data %h cnt %0d half %b exp 0 0 0000 0 0",
                        src_rdy, dst_val, dst_data, word_cnt, half_pend);
    end
    rst = 1'b0; dst_rdy = 1'b1;
    drive(1'b1, 8'h9A); step();
    drive(1'b1, 8'hBC); step();
    src_val = 1'b0; #1;
    tests++; if (dst_val !== 1'b1 || dst_data !== 16'h9ABC) begin fails++; $display("FAIL rst_after got val %b data %h exp 1 9abc", dst_val, dst_data); end
    step();
    tests++; if (word_cnt !== 16'd1) begin fails++; $display("FAIL rst_after_cnt got %0d exp 1", word_cnt); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; step(); rst = 1'b0;
    dst_rdy = 1'b1;
    for (int i = 0; i < 34; i++) begin
      drive(1'b1, 8'(i)); step();
    end
    src_val = 1'b0; #1;
    tests++; if (s_dst_data !== 16'h2021) begin fails++; $display("FAIL wrap_last_data got %h exp 2021", s_dst_data); end
    step();
    tests++; if (s_word_cnt !== 4'd1)  begin fails++; $display("FAIL wrap_cnt4 got %0d exp 1", s_word_cnt); end
    tests++; if (word_cnt !== 16'd17) begin fails++; $display("FAIL wrap_cnt16 got %0d exp 17", word_cnt); end
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b1; cfg_flush = 1'b0;
    src_val = 1'b0; src_data = 8'h00; dst_rdy = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_enable();
    test_rst_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
